// File: rtl/frame_pkg.sv
// Shared definitions for the serial frame generator and receiver: FSM state
// encoding, line idle level and the even-parity helper.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Value of the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/frame_rx_hold.sv
// One-deep holding register for frame_rx: captures a completed word and its
// error flags, runs the rx_valid/rx_ack handshake and tracks dropped frames.
module frame_rx_hold #(
    parameter int DATA_W = 12
) (
    input  logic              clk_serial_bits,
    input  logic              rst,
    input  logic              done,
    input  logic [DATA_W-1:0] done_word,
    input  logic              done_frame_err,
    input  logic              done_parity_err,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_word,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    // NOTE: non-blocking assignments so every flop sees pre-edge values,
    // regardless of statement order or which block reads them.
    // NOTE: the held word is reset as well, so a consumer never sees stale data.
    always_ff @(posedge clk_serial_bits or negedge rst) begin
        if (!rst) begin
            rx_word    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rx_ack) begin
                rx_word    <= done_word;
                frame_err  <= done_frame_err;
                parity_err <= done_parity_err;
                rx_valid   <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                // Consumer still holds the previous word: drop the new one.
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity bit (macro FRAME_PARITY_EN), STOP_BITS stop bits; one sample per bit.
module frame_rx #(
    parameter int DATA_W    = 12,
    parameter int STOP_BITS = 1
) (
    input  logic              rst,
    input  logic              clk_serial_bits,
    input  logic              signal,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_word,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    import frame_pkg::*;

    localparam int MAX_W = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    frame_state_t      state, state_next;
    logic [CNT_W-1:0]  bit_cnt, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              done, done_frame_err, done_parity_err;

    // NOTE: every combinational output is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        cnt_next       = bit_cnt;
        shift_next     = shift_reg;
        done           = 1'b0;
        done_frame_err = 1'b0;
        case (state)
            IDLE: begin
                if (signal != IDLE_LEVEL) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            end
            DATA: begin
                // Bits arrive LSB first; after DATA_W shifts bit k sits at index k.
                shift_next = (shift_reg >> 1) | (DATA_W'(signal) << (DATA_W - 1));
                if (bit_cnt == DATA_LAST) begin
`ifdef FRAME_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
                    cnt_next   = '0;
`endif
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
`ifdef FRAME_PARITY_EN
            PARITY: begin
                state_next = STOP;
                cnt_next   = '0;
            end
`endif
            STOP: begin
                if (signal != IDLE_LEVEL) begin
                    // A low stop bit ends the frame here; it is not a new start bit.
                    done           = 1'b1;
                    done_frame_err = 1'b1;
                    state_next     = IDLE;
                end else if (bit_cnt == STOP_LAST) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_serial_bits or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            shift_reg <= shift_next;
            busy      <= (state_next != IDLE);
        end
    end

`ifdef FRAME_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk_serial_bits or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (state == PARITY) begin
            par_err_q <= (signal != even_parity(32'(shift_reg)));
        end
    end

    assign done_parity_err = par_err_q;
`else
    assign done_parity_err = 1'b0;
`endif

    frame_rx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_serial_bits (clk_serial_bits),
        .rst             (rst),
        .done            (done),
        .done_word       (shift_reg),
        .done_frame_err  (done_frame_err),
        .done_parity_err (done_parity_err),
        .rx_ack          (rx_ack),
        .rx_word         (rx_word),
        .rx_valid        (rx_valid),
        .frame_err       (frame_err),
        .parity_err      (parity_err),
        .overrun         (overrun)
    );

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: frames are built bit by bit into a queue tagged with the
// expected frame-level outcome; a handshake model predicts the outputs.
module tb_frame_rx;

    localparam int DATA_W    = 12;
    localparam int STOP_BITS = 1;
`ifdef FRAME_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk_serial_bits = 1'b0;
    logic              rst = 1'b1;
    logic              signal = 1'b1;
    logic              rx_ack = 1'b0;
    logic [DATA_W-1:0] rx_word;
    logic              rx_valid, frame_err, parity_err, overrun, busy;

    frame_rx #(
        .DATA_W    (DATA_W),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .rst             (rst),
        .clk_serial_bits (clk_serial_bits),
        .signal          (signal),
        .rx_ack          (rx_ack),
        .rx_word         (rx_word),
        .rx_valid        (rx_valid),
        .frame_err       (frame_err),
        .parity_err      (parity_err),
        .overrun         (overrun),
        .busy            (busy)
    );

    always #5 clk_serial_bits = ~clk_serial_bits;

    // One line bit plus what the receiver should conclude once it samples it.
    typedef struct packed {
        logic              bit_val;
        logic              complete;
        logic [DATA_W-1:0] word;
        logic              ferr;
        logic              perr;
        logic              busy_after;
    } tag_t;

    tag_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_mode = 0;  // 0 never, 1 random, 2 on completing bits, 3 always

    logic              m_valid, m_ferr, m_perr, m_ovr, m_busy;
    logic [DATA_W-1:0] m_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
        m_word  = '0;
    endtask

    task automatic push_bit(input logic b, input logic c, input logic [DATA_W-1:0] w,
                            input logic fe, input logic pe, input logic ba);
        tag_t t;
        t.bit_val = b; t.complete = c; t.word = w; t.ferr = fe; t.perr = pe; t.busy_after = ba;
        q.push_back(t);
    endtask

    task automatic queue_frame(input logic [DATA_W-1:0] word, input bit parity_ok,
                               input int bad_stop, input int gap);
        logic pe;
        pe = PAR_EN && !parity_ok;
        for (int g = 0; g < gap; g++) push_bit(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        push_bit(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < DATA_W; k++) push_bit(word[k], 1'b0, '0, 1'b0, 1'b0, 1'b1);
        if (PAR_EN) push_bit((^word) ^ !parity_ok, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < STOP_BITS; j++) begin
            if (j == bad_stop) begin
                push_bit(1'b0, 1'b1, word, 1'b1, pe, 1'b0);
                return;
            end else if (j == STOP_BITS - 1) begin
                push_bit(1'b1, 1'b1, word, 1'b0, pe, 1'b0);
            end else begin
                push_bit(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            end
        end
    endtask

    // Called just after a falling edge: drive one bit, model the rising edge,
    // then compare at the next falling edge.
    task automatic step();
        tag_t t;
        logic a;
        if (q.size() > 0) begin
            t = q.pop_front();
        end else begin
            t = '0;
            t.bit_val = 1'b1;
        end
        case (ack_mode)
            0:       a = 1'b0;
            1:       a = ($urandom_range(0, 3) == 0);
            2:       a = t.complete;
            default: a = 1'b1;
        endcase
        signal = t.bit_val;
        rx_ack = a;
        @(posedge clk_serial_bits);
        if (t.complete) begin
            if (!m_valid || a) begin
                m_valid = 1'b1; m_word = t.word; m_ferr = t.ferr; m_perr = t.perr; m_ovr = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && a) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        m_busy = t.busy_after;
        @(negedge clk_serial_bits);
        check("rx_valid", 32'(rx_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("busy", 32'(busy), 32'(m_busy));
        if (m_valid) begin
            check("rx_word", 32'(rx_word), 32'(m_word));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            check("parity_err", 32'(parity_err), 32'(m_perr));
        end
    endtask

    task automatic drain();
        while (q.size() > 0) step();
        step();
    endtask

    task automatic ack_once();
        ack_mode = 3;
        step();
        ack_mode = 0;
    endtask

    initial begin
        tag_t t;
        model_reset();
        #1 rst = 1'b0;
        #1;
        check("reset rx_valid", 32'(rx_valid), 0);
        check("reset rx_word", 32'(rx_word), 0);
        check("reset flags", 32'({frame_err, parity_err, overrun, busy}), 0);
        @(negedge clk_serial_bits);
        rst = 1'b1;

        // Plain frame, no ack
        queue_frame(12'hA5C, 1'b1, -1, 0);
        drain();
        check("a5c word", 32'(rx_word), 32'h0A5C);
        check("a5c valid", 32'(rx_valid), 1);
        check("a5c ferr", 32'(frame_err), 0);
        check("a5c ovr", 32'(overrun), 0);
        ack_once();
        check("a5c acked", 32'(rx_valid), 0);

        // Bad stop bit, then a good frame
        queue_frame(12'hA5C, 1'b1, 0, 0);
        drain();
        check("stop0 valid", 32'(rx_valid), 1);
        check("stop0 ferr", 32'(frame_err), 1);
        check("stop0 idle", 32'(busy), 0);
        ack_once();
        queue_frame(12'h123, 1'b1, -1, 0);
        drain();
        check("after err word", 32'(rx_word), 32'h123);
        check("after err ferr", 32'(frame_err), 0);
        ack_once();

        // Back to back without ack: second frame is dropped
        queue_frame(12'h001, 1'b1, -1, 0);
        queue_frame(12'hFFF, 1'b1, -1, 0);
        drain();
        check("ovr word", 32'(rx_word), 32'h001);
        check("ovr flag", 32'(overrun), 1);
        ack_once();
        check("ovr cleared valid", 32'(rx_valid), 0);
        check("ovr cleared flag", 32'(overrun), 0);

        // Ack on the very edge the second frame completes
        ack_mode = 2;
        queue_frame(12'h001, 1'b1, -1, 0);
        queue_frame(12'hFFF, 1'b1, -1, 0);
        drain();
        ack_mode = 0;
        check("same-edge word", 32'(rx_word), 32'hFFF);
        check("same-edge valid", 32'(rx_valid), 1);
        check("same-edge ovr", 32'(overrun), 0);
        ack_once();

`ifdef FRAME_PARITY_EN
        queue_frame(12'h007, 1'b1, -1, 0);
        drain();
        check("parity good", 32'(parity_err), 0);
        ack_once();
        queue_frame(12'h007, 1'b0, -1, 0);
        drain();
        check("parity bad", 32'(parity_err), 1);
        ack_once();
`endif

        // Reset while data bit 5 is on the line, with a word already held
        queue_frame(12'h3C3, 1'b1, -1, 0);
        drain();
        queue_frame(12'h5A5, 1'b1, -1, 0);
        repeat (6) step();
        t = q.pop_front();
        signal = t.bit_val;
        #2 rst = 1'b0;
        #1;
        check("midrst rx_valid", 32'(rx_valid), 0);
        check("midrst rx_word", 32'(rx_word), 0);
        check("midrst flags", 32'({frame_err, parity_err, overrun, busy}), 0);
        q.delete();
        model_reset();
        signal = 1'b1;
        rx_ack = 1'b0;
        @(negedge clk_serial_bits);
        @(negedge clk_serial_bits);
        rst = 1'b1;
        queue_frame(12'h800, 1'b1, -1, 0);
        drain();
        check("post-rst word", 32'(rx_word), 32'h800);
        check("post-rst valid", 32'(rx_valid), 1);
        ack_once();

        // Random frames, gaps, stop errors, parity errors and ack timing
        ack_mode = 1;
        for (int f = 0; f < 150; f++) begin
            queue_frame(DATA_W'($urandom),
                        ($urandom_range(0, 4) != 0),
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, STOP_BITS - 1)) : -1,
                        int'($urandom_range(0, 2)));
        end
        drain();
        ack_once();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_rx.md
# frame_rx

Parametrised serial frame receiver. Deframes the one-sample-per-bit NRZ stream produced by the frame generator on the shared bit clock. Delivers each word through a one-deep holding register with a valid/ack handshake, and flags framing, parity and overrun errors. It sits between the channel demodulator output and the word consumer.

## Interface
- DATA_W, 12, data bits per frame, 1..32, sent LSB first
- STOP_BITS, 1, stop bits checked per frame, 1..8
- rst  in  1  reset rst, asynchronous, active-low
- clk_serial_bits  in  1  clock clk_serial_bits, one edge per serial bit
- signal  in  1  serial line, idle high
- rx_ack  in  1  consumer accepts held word
- rx_word  out  DATA_W  held received word
- rx_valid  out  1  rx_word/status valid, held until acked
- frame_err  out  1  stop bit sampled 0; qualified by rx_valid
- parity_err  out  1  parity mismatch; qualified by rx_valid; tied 0 without macro
- overrun  out  1  at least one completed frame dropped while rx_valid held
- busy  out  1  frame in progress (state != IDLE)

## Operation
- FSM states: IDLE, DATA, PARITY (only with macro), STOP.
- IDLE: when signal==0 at an edge, go to DATA with bit_cnt=0 and the shift register cleared. Otherwise stay in IDLE.
- DATA: at each edge, store signal into bit position bit_cnt. When bit_cnt==DATA_W-1, go to PARITY or STOP.
- PARITY: sample one bit and compare it with the even parity of the data bits. Then go to STOP with bit_cnt=0.
- STOP: sample STOP_BITS bits, each of which must be 1.
  - A 0 ends the frame immediately with frame_err=1, and the FSM returns to IDLE.
  - That 0 is not taken as a start bit.
  - After the last good stop bit, the frame completes normally.
- Completion, in priority order at the completing edge:
  - If rx_valid==0, or rx_valid==1 with rx_ack==1 at the same edge: load rx_word and the error flags, set rx_valid=1, clear overrun.
  - If rx_valid==1 with rx_ack==0: discard the new frame, keep the held word and flags, set overrun=1.
- Handshake: rx_valid==1 with rx_ack==1 at an edge, and no completion at that edge, gives rx_valid=0 and overrun=0. rx_ack while rx_valid==0 is ignored.
- Error flags and rx_word are stable while rx_valid==1.
- bit_cnt width is $clog2 of max(DATA_W, STOP_BITS), minimum 1.
- Reset (any time, including mid-frame):
  - state=IDLE, bit_cnt=0
  - rx_word=0, rx_valid=0
  - frame_err=0, parity_err=0, overrun=0, busy=0
  - shift register cleared

## Timing
- Start bit sampled at edge N. Data bit k sampled at edge N+1+k.
- Parity bit sampled at N+1+DATA_W when the macro is on.
- Stop bit j sampled at N+1+DATA_W+P+j, where P is 1 with the macro and 0 without.
- rx_valid rises after the last stop edge E = N+DATA_W+P+STOP_BITS. busy falls at the same edge.
- A new start bit is detectable from edge E+1, so back-to-back frames with zero idle gap are supported.
- On a framing error at stop bit j, completion happens at that edge. IDLE resumes at the next edge.
- All outputs are registered. There is no combinational path from signal or rx_ack to any output.

## Configuration
- FRAME_PARITY_EN defined:
  - Each frame carries one even-parity bit between data and stop.
  - parity_err reports a mismatch.
  - Frame length is 1+DATA_W+1+STOP_BITS bits.
- FRAME_PARITY_EN undefined:
  - No PARITY state and no parity logic.
  - parity_err is constant 0.
  - Frame length is 1+DATA_W+STOP_BITS bits.

## Structure
- Shared package frame_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP)
  - an even-parity function
  - the constant IDLE_LEVEL=1'b1
- The generator side imports the same package.
- One sub-module: frame_rx_hold.
  - Contains the holding register, the rx_valid/rx_ack handshake and overrun logic.
  - Takes a one-cycle completion strobe plus word and flags from the FSM.

## Test plan
- DATA_W=12, STOP_BITS=1, no macro, frame 0 + 12'hA5C LSB first + 1 -> rx_valid rises after edge N+13; rx_word=12'hA5C; frame_err=0; overrun=0.
- Same frame but stop bit 0 -> rx_valid=1, frame_err=1, FSM back in IDLE at the next edge; a following valid frame 12'h123 decodes correctly after ack.
- Two back-to-back frames 12'h001 and 12'hFFF, rx_ack never asserted -> rx_word stays 12'h001, overrun=1; ack gives rx_valid=0, overrun=0.
- rx_ack at the same edge the second frame completes -> rx_valid stays 1, rx_word=12'hFFF, overrun=0.
- FRAME_PARITY_EN, word 12'h007 (three ones) with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
- rst low at data bit 5 of a frame -> all outputs 0 and busy=0 immediately; after release, a full frame 12'h800 decodes correctly.
